// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, funct3 encodings, sequencer states
// and the implemented-CSR lookup used by the optional access check.
package csr_pkg;

  localparam int XLEN = 32;

  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MISA       = 12'h301;
  localparam logic [11:0] CSR_MIE        = 12'h304;
  localparam logic [11:0] CSR_MTVEC      = 12'h305;
  localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [11:0] CSR_MIP        = 12'h344;
  localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
  localparam logic [11:0] CSR_MARCHID    = 12'hF12;
  localparam logic [11:0] CSR_MIMPID     = 12'hF13;
  localparam logic [11:0] CSR_MHARTID    = 12'hF14;

  // funct3[1:0] selects the operation, funct3[2] the zimm form
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;
  localparam int         F3_IMM_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_DONE
  } csr_state_e;

  localparam int N_IMPL = 16;

  localparam logic [11:0] CSR_IMPL [N_IMPL] = '{
    CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC,
    CSR_MCOUNTEREN, CSR_MEPC, CSR_MCAUSE, CSR_MIP,
    CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH,
    CSR_MINSTRETH, CSR_MVENDORID, CSR_MARCHID,
    CSR_MIMPID, CSR_MHARTID
  };

  function automatic logic csr_implemented(
    input logic [11:0] addr
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_IMPL; i++) begin
      if (CSR_IMPL[i] == addr) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/csr_wdata_calc.sv
// csr_wdata_calc: new CSR value for RW/RS/RC from old value and operand.
// Ports: op_i (funct3[1:0]), old_i, operand_i -> new_o. Combinational.
module csr_wdata_calc
  import csr_pkg::*;
(
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] operand_i,
  output logic [XLEN-1:0] new_o
);

  always_comb begin
    new_o = old_i;
    unique case (op_i)
      OP_RW:   new_o = operand_i;
      OP_RS:   new_o = old_i | operand_i;
      OP_RC:   new_o = old_i & ~operand_i;
      default: new_o = old_i;
    endcase
  end

endmodule

// File: rtl/csr_access_seq.sv
// csr_access_seq: sequences one Zicsr instruction into read, capture
// and write-back cycles on the single-port CSR file bus.
// Ports: clk_i, rst_i (async, active-high); request side req_valid_i,
//   req_ready_o, funct3_i, csr_addr_i, rs1_data_i, zimm_i, rd_zero_i,
//   rs1_zero_i; result done_o, rd_data_o, illegal_o; CSR bus
//   csr_addr_o, csr_re_o, csr_we_o, csr_wdata_o, csr_rdata_i.
// Option: CSR_ACCESS_CHECK_EN enables the illegal-access check.
module csr_access_seq
  import csr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  funct3_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] rs1_data_i,
  input  logic [4:0]  zimm_i,
  input  logic        rd_zero_i,
  input  logic        rs1_zero_i,
  output logic        done_o,
  output logic [31:0] rd_data_o,
  output logic        illegal_o,
  output logic [31:0] csr_addr_o,
  output logic        csr_re_o,
  output logic        csr_we_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] csr_rdata_i
);

  csr_state_e  state_q, state_d;
  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] operand_q;
  logic [31:0] old_q;
  logic        ro_q;
  logic [31:0] operand_in;
  logic [31:0] new_val;
  logic        accept;
  logic        bad;
  logic        skip_rd;
  logic        full_rd;

  assign accept     = (state_q == ST_IDLE) && req_valid_i;
  assign operand_in = funct3_i[F3_IMM_BIT]
                    ? {27'b0, zimm_i} : rs1_data_i;

`ifdef CSR_ACCESS_CHECK_EN
  logic wr_try;
  logic ill_q;

  // RW always writes; RS/RC write unless the source is zero
  assign wr_try = (funct3_i[1:0] == OP_RW) || !rs1_zero_i;
  assign bad = (funct3_i[1:0] == OP_NONE)
            || !csr_implemented(csr_addr_i)
            || ((csr_addr_i[11:10] == 2'b11) && wr_try);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ill_q <= 1'b0;
    end else if (accept) begin
      ill_q <= bad;
    end
  end

  assign illegal_o = (state_q == ST_DONE) && ill_q;
`else
  assign bad       = (funct3_i[1:0] == OP_NONE);
  assign illegal_o = 1'b0;
`endif

  // the three accept paths are mutually exclusive
  assign skip_rd = !bad && (funct3_i[1:0] == OP_RW)
                && rd_zero_i;
  assign full_rd = !bad && !skip_rd;

  csr_wdata_calc u_calc (
    .op_i      (op_q),
    .old_i     (old_q),
    .operand_i (operand_q),
    .new_o     (new_val)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NONE;
      addr_q    <= '0;
      operand_q <= '0;
      old_q     <= '0;
      ro_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= funct3_i[1:0];
        addr_q    <= csr_addr_i;
        operand_q <= operand_in;
        ro_q      <= rs1_zero_i;
        old_q     <= '0;
      end
      if (state_q == ST_CAP) begin
        old_q <= csr_rdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          unique case (1'b1)
            bad:     state_d = ST_DONE;
            skip_rd: state_d = ST_WR;
            full_rd: state_d = ST_RD;
            default: state_d = ST_RD;
          endcase
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP: begin
        if ((op_q != OP_RW) && ro_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs decode straight from state so reset drops them at once
  always_comb begin
    req_ready_o = 1'b0;
    done_o      = 1'b0;
    rd_data_o   = '0;
    csr_addr_o  = '0;
    csr_re_o    = 1'b0;
    csr_we_o    = 1'b0;
    csr_wdata_o = '0;
    unique case (state_q)
      ST_IDLE: req_ready_o = 1'b1;
      ST_RD: begin
        csr_re_o   = 1'b1;
        csr_addr_o = {20'b0, addr_q};
      end
      ST_WR: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = {20'b0, addr_q};
        csr_wdata_o = new_val;
      end
      ST_DONE: begin
        done_o    = 1'b1;
        rd_data_o = old_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_access_seq.sv
// tb_csr_access_seq: scoreboard bench for csr_access_seq with a
// behavioural CSR file on the bus and an independent reference model.
module tb_csr_access_seq;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  funct3_i = '0;
  logic [11:0] csr_addr_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [4:0]  zimm_i = '0;
  logic        rd_zero_i = 1'b0;
  logic        rs1_zero_i = 1'b0;
  logic        done_o;
  logic [31:0] rd_data_o;
  logic        illegal_o;
  logic [31:0] csr_addr_o;
  logic        csr_re_o;
  logic        csr_we_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i = '0;

  csr_access_seq dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .funct3_i    (funct3_i),
    .csr_addr_i  (csr_addr_i),
    .rs1_data_i  (rs1_data_i),
    .zimm_i      (zimm_i),
    .rd_zero_i   (rd_zero_i),
    .rs1_zero_i  (rs1_zero_i),
    .done_o      (done_o),
    .rd_data_o   (rd_data_o),
    .illegal_o   (illegal_o),
    .csr_addr_o  (csr_addr_o),
    .csr_re_o    (csr_re_o),
    .csr_we_o    (csr_we_o),
    .csr_wdata_o (csr_wdata_o),
    .csr_rdata_i (csr_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rd;
    logic        ill;
    int          lat;
    int          nre;
    int          acc;
  } exp_t;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } wexp_t;

  exp_t  dq[$];
  wexp_t wq[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int nre = 0;
  int done_cnt = 0;
  logic [11:0] cur_a = '0;

  logic [31:0] fmem [4096];
  logic [31:0] rmem [4096];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h306,
      12'h341, 12'h342, 12'h344,
      12'hB00, 12'hB02, 12'hB80, 12'hB82,
      12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic writable(input logic [11:0] a);
    return impl(a) && (a[11:10] != 2'b11);
  endfunction

  // CSR file: registered read data, write wins over read
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (csr_we_o) begin
      if (writable(csr_addr_o[11:0]))
        fmem[csr_addr_o[11:0]] <= csr_wdata_o;
    end else if (csr_re_o) begin
      csr_rdata_i <= impl(csr_addr_o[11:0])
                   ? fmem[csr_addr_o[11:0]] : 32'h0;
    end
  end

  always @(negedge clk_i) begin
    exp_t  e;
    wexp_t w;
    if (!rst_i) begin
      if (!csr_re_o && !csr_we_o)
        chk("bus_idle_addr", csr_addr_o, 32'h0);
      if (!csr_we_o)
        chk("bus_idle_wdata", csr_wdata_o, 32'h0);
      if (!done_o)
        chk("rd_idle", rd_data_o, 32'h0);
      if (csr_re_o) begin
        nre++;
        chk("re_we_excl", {31'b0, csr_we_o}, 32'h0);
        chk("rd_addr", csr_addr_o, {20'b0, cur_a});
      end
      if (csr_we_o) begin
        chk("wr_pending", {31'b0, wq.size() != 0}, 32'h1);
        if (wq.size() != 0) begin
          w = wq.pop_front();
          chk("wr_addr", csr_addr_o, {20'b0, w.a});
          chk("wr_data", csr_wdata_o, w.d);
        end
      end
      if (done_o) begin
        chk("done_pending", {31'b0, dq.size() != 0}, 32'h1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          chk("rd_data", rd_data_o, e.rd);
          chk("illegal", {31'b0, illegal_o}, {31'b0, e.ill});
          chk("latency", cyc - e.acc + 1, e.lat);
          chk("read_cnt", nre, e.nre);
          chk("wr_left", wq.size(), 32'h0);
        end
        nre = 0;
        done_cnt++;
      end
    end
  end

  task automatic run_op(input logic [2:0]  f,
                        input logic [11:0] a,
                        input logic [31:0] rs1,
                        input logic [4:0]  zi,
                        input logic        rdz,
                        input logic        r1z);
    exp_t  e;
    wexp_t w;
    logic [31:0] op, old, nw;
    logic [1:0]  k;
    logic        ill, wr, rd;
    int          lat, seen;
    op  = f[2] ? {27'b0, zi} : rs1;
    k   = f[1:0];
    ill = 1'b0;
    wr  = 1'b0;
    rd  = 1'b0;
    old = 32'h0;
`ifdef CSR_ACCESS_CHECK_EN
    ill = (k == 2'b00) || !impl(a)
       || ((a[11:10] == 2'b11) && ((k == 2'b01) || !r1z));
`endif
    if (ill || k == 2'b00) begin
      lat = 1;
    end else if (k == 2'b01 && rdz) begin
      lat = 2;
      wr  = 1'b1;
    end else begin
      rd  = 1'b1;
      old = impl(a) ? rmem[a] : 32'h0;
      if (k != 2'b01 && r1z) lat = 3;
      else begin
        lat = 4;
        wr  = 1'b1;
      end
    end
    case (k)
      2'b01:   nw = op;
      2'b10:   nw = old | op;
      default: nw = old & ~op;
    endcase
    if (wr) begin
      w.a = a;
      w.d = nw;
      wq.push_back(w);
      if (writable(a)) rmem[a] = nw;
    end
    e.rd  = rd ? old : 32'h0;
    e.ill = ill;
    e.lat = lat;
    e.nre = rd ? 1 : 0;
    @(negedge clk_i);
    funct3_i    = f;
    csr_addr_i  = a;
    rs1_data_i  = rs1;
    zimm_i      = zi;
    rd_zero_i   = rdz;
    rs1_zero_i  = r1z;
    cur_a       = a;
    req_valid_i = 1'b1;
    seen = done_cnt;
    @(posedge clk_i);
    #1;
    e.acc = cyc;
    dq.push_back(e);
    chk("accepted", {31'b0, req_ready_o}, 32'h0);
    // request stays valid while busy; it must be ignored
    for (int i = 0; i < 8 && done_cnt == seen; i++) begin
      @(negedge clk_i);
      #1;
    end
    if (done_cnt == seen)
      chk("done_timeout", done_cnt, seen + 1);
    req_valid_i = 1'b0;
  endtask

  logic [11:0] pick [18] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h306,
    12'h341, 12'h342, 12'h344, 12'hB00, 12'hB02,
    12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'hF13,
    12'hF14, 12'h7C0, 12'h340
  };

  initial begin
    logic [2:0]  f;
    logic [11:0] a;
    logic [31:0] r;
    logic [4:0]  z;
    logic        rdz, r1z;
    int          hit;
    for (int i = 0; i < 4096; i++) begin
      fmem[i] = 32'h0;
      rmem[i] = 32'h0;
    end
    fmem[12'hF14] = 32'h5;
    rmem[12'hF14] = 32'h5;

    @(posedge clk_i);
    #1;
    chk("rst_ready", {31'b0, req_ready_o}, 32'h1);
    chk("rst_done", {31'b0, done_o}, 32'h0);
    chk("rst_re", {31'b0, csr_re_o}, 32'h0);
    chk("rst_we", {31'b0, csr_we_o}, 32'h0);
    chk("rst_addr", csr_addr_o, 32'h0);
    chk("rst_wdata", csr_wdata_o, 32'h0);
    chk("rst_rd", rd_data_o, 32'h0);
    chk("rst_ill", {31'b0, illegal_o}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    run_op(3'b001, 12'h305, 32'h1000, 5'd0, 1'b0, 1'b0);
    run_op(3'b010, 12'h305, 32'h0, 5'd0, 1'b0, 1'b1);
    run_op(3'b001, 12'h304, 32'h800, 5'd0, 1'b0, 1'b0);
    run_op(3'b010, 12'h304, 32'h88, 5'd0, 1'b0, 1'b0);
    run_op(3'b111, 12'h304, 32'h0, 5'd8, 1'b0, 1'b0);
    run_op(3'b010, 12'h304, 32'h0, 5'd0, 1'b0, 1'b1);
    run_op(3'b001, 12'h341, 32'hDEAD, 5'd0, 1'b1, 1'b0);
    run_op(3'b010, 12'hF14, 32'h0, 5'd0, 1'b0, 1'b1);
    run_op(3'b000, 12'h300, 32'h1234, 5'd3, 1'b0, 1'b0);
    run_op(3'b100, 12'h305, 32'h0, 5'd7, 1'b0, 1'b0);
    run_op(3'b101, 12'hF11, 32'h0, 5'd9, 1'b0, 1'b0);
    run_op(3'b001, 12'h7C0, 32'h55, 5'd0, 1'b0, 1'b0);
    run_op(3'b010, 12'h341, 32'h0, 5'd0, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      f   = 3'($urandom_range(0, 7));
      a   = pick[$urandom_range(0, 17)];
      rdz = 1'($urandom_range(0, 1));
      r1z = 1'($urandom_range(0, 1));
      r   = r1z ? 32'h0 : $urandom;
      z   = r1z ? 5'd0 : 5'($urandom_range(1, 31));
      run_op(f, a, r, z, rdz, r1z);
    end

    // reset while the write is on the bus
    @(negedge clk_i);
    funct3_i    = 3'b001;
    csr_addr_i  = 12'h305;
    rs1_data_i  = 32'hBEEF;
    rd_zero_i   = 1'b0;
    rs1_zero_i  = 1'b0;
    cur_a       = 12'h305;
    req_valid_i = 1'b1;
    hit = 0;
    for (int i = 0; i < 6 && hit == 0; i++) begin
      @(posedge clk_i);
      #1;
      if (csr_we_o) hit = 1;
    end
    chk("rst_mid_reach_wr", hit, 1);
    rst_i = 1'b1;
    #1;
    req_valid_i = 1'b0;
    chk("rst_mid_we", {31'b0, csr_we_o}, 32'h0);
    chk("rst_mid_ready", {31'b0, req_ready_o}, 32'h1);
    chk("rst_mid_addr", csr_addr_o, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    dq.delete();
    wq.delete();
    nre = 0;
    @(posedge clk_i);
    #1;
    chk("rst_mtvec_kept", fmem[12'h305], rmem[12'h305]);
    chk("rst_post_ready", {31'b0, req_ready_o}, 32'h1);

    run_op(3'b010, 12'h305, 32'h0, 5'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
